dmc_bit_deframer: RTL

Downstream stage of the differential-Manchester edge decoder. It consumes the decoded serial bit stream and its sync marker, aligns to the frame start, and removes the additive scrambler. It packs bits MSB-first into parallel words and delivers them through a 2-entry output FIFO with a valid/ready handshake, which feeds the channel demux.

---
 rtl/dmc_pkg.sv | 24 ++
 rtl/dmc_word_fifo.sv | 93 +++++++++
 rtl/dmc_bit_deframer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dmc_pkg.sv
// rtl/dmc_pkg.sv - shared types and descrambler constants for the DMC deframer
//
// Purpose : state encoding, LFSR tap positions, default seed and the LFSR
//           next-state helper shared by the deframer files.
// Ports   : none (package).
package dmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_SYNCED = 2'd2
    } dmc_state_e;

    localparam int         LFSR_W        = 7;
    localparam int         LFSR_TAP_HI   = 6;
    localparam int         LFSR_TAP_LO   = 3;
    localparam logic [6:0] LFSR_SEED_DEF = 7'h7F;

    // Fibonacci step: shift left, feed back x^7 + x^4 taps into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[LFSR_TAP_HI] ^ l[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/dmc_word_fifo.sv
// rtl/dmc_word_fifo.sv - 2-entry output word FIFO with drop-on-full
//
// Purpose : holds deframed words for the downstream consumer. The head entry
//           is a dedicated register so the output word is directly registered.
// Ports   : clk_i, reset_n_period (async, active-low)
//           i_clr   - synchronous flush of entries and the overflow flag
//           i_push  - write i_data (dropped when full with no pop)
//           i_data  - word to write
//           i_rdy   - consumer ready; pop when o_vld & i_rdy
//           o_data  - head entry
//           o_vld   - FIFO not empty
//           o_ovf   - sticky: a push was dropped
module dmc_word_fifo #(
    parameter int WORD_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_n_period,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_rdy,
    output logic [WORD_W-1:0] o_data,
    output logic              o_vld,
    output logic              o_ovf
);

    logic [1:0]        r_cnt;
    logic [WORD_W-1:0] r_head;
    logic [WORD_W-1:0] r_tail;
    logic              r_vld;
    logic              r_ovf;

    logic w_pop;
    logic w_empty;
    logic w_full;

    assign w_empty = (r_cnt == 2'd0);
    assign w_full  = (r_cnt == 2'd2);
    assign w_pop   = r_vld & i_rdy;

    always_ff @(posedge clk_i or negedge reset_n_period) begin
        if (!reset_n_period) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
            r_vld  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (i_clr) begin
            // A push coinciding with the flush survives as the only entry.
            r_ovf <= 1'b0;
            if (i_push) begin
                r_head <= i_data;
                r_cnt  <= 2'd1;
                r_vld  <= 1'b1;
            end else begin
                r_cnt  <= 2'd0;
                r_vld  <= 1'b0;
            end
        end else if (w_empty) begin
            if (i_push) begin
                r_head <= i_data;
                r_cnt  <= 2'd1;
                r_vld  <= 1'b1;
            end
        end else if (w_full) begin
            if (w_pop) begin
                r_head <= r_tail;
                if (i_push) begin
                    r_tail <= i_data;
                end else begin
                    r_cnt  <= 2'd1;
                end
            end else if (i_push) begin
                r_ovf <= 1'b1;
            end
        end else begin
            if (i_push && w_pop) begin
                r_head <= i_data;
            end else if (i_push) begin
                r_tail <= i_data;
                r_cnt  <= 2'd2;
            end else if (w_pop) begin
                r_cnt  <= 2'd0;
                r_vld  <= 1'b0;
            end
        end
    end

    assign o_data = r_head;
    assign o_vld  = r_vld;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/dmc_bit_deframer.sv
// rtl/dmc_bit_deframer.sv - frame alignment, descrambling and word packing
//
// Purpose : aligns the decoded bit stream to the sync marker, removes the
//           additive scrambler, packs bits MSB-first into words and queues
//           them in a 2-entry FIFO.
// Ports   : clk_i, reset_n_period (async, active-low)
//           dec_en_i, bit_stb_i, bit_i, sync_i - upstream decoder stream
//           clr_i        - clears sticky flags and the FIFO
//           word_o/word_vld_o/word_rdy_i - output word handshake
//           frame_done_o - pulse with the last word of a frame
//           locked_o     - frame alignment held
//           ovf_o, sync_err_o - sticky error flags
module dmc_bit_deframer
    import dmc_pkg::*;
#(
    parameter int         WORD_W      = 16,
    parameter int         FRAME_WORDS = 4,
    parameter logic [6:0] LFSR_SEED   = LFSR_SEED_DEF
) (
    input  logic              clk_i,
    input  logic              reset_n_period,
    input  logic              dec_en_i,
    input  logic              bit_stb_i,
    input  logic              bit_i,
    input  logic              sync_i,
    input  logic              clr_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_vld_o,
    input  logic              word_rdy_i,
    output logic              frame_done_o,
    output logic              locked_o,
    output logic              ovf_o,
    output logic              sync_err_o
);

    localparam int             BCW       = $clog2(WORD_W);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_W - 1);
    localparam logic [7:0]     LAST_WORD = 8'(FRAME_WORDS - 1);

    dmc_state_e        r_state;
    logic              r_sync_d;
    logic [6:0]        r_lfsr;
    logic [WORD_W-2:0] r_sh;
    logic [BCW-1:0]    r_bit_cnt;
    logic [7:0]        r_word_cnt;
    logic              r_frame_done;
    logic              r_locked;
    logic              r_sync_err;

    logic              w_sync_rise;
    logic              w_restart;
    logic              w_active;
    logic              w_take;
    logic              w_partial;
    logic [6:0]        w_lfsr_base;
    logic [WORD_W-2:0] w_sh_base;
    logic [BCW-1:0]    w_bit_base;
    logic [7:0]        w_word_base;
    logic              w_d;
    logic              w_push;
    logic              w_last_word;
    logic [WORD_W-1:0] w_word_data;

    assign w_sync_rise = sync_i & ~r_sync_d;
    assign w_partial   = (r_bit_cnt != '0) || (r_word_cnt != 8'd0);

    // A detected sync edge restarts the frame in the same cycle, so a
    // coincident strobe is processed against the freshly seeded state.
    assign w_restart   = dec_en_i & w_sync_rise &
                         ((r_state == ST_HUNT) || (r_state == ST_SYNCED));
    assign w_active    = dec_en_i & ((r_state == ST_SYNCED) | w_restart);
    assign w_take      = w_active & bit_stb_i;

    assign w_lfsr_base = w_restart ? LFSR_SEED : r_lfsr;
    assign w_sh_base   = w_restart ? '0        : r_sh;
    assign w_bit_base  = w_restart ? '0        : r_bit_cnt;
    assign w_word_base = w_restart ? 8'd0      : r_word_cnt;

    assign w_d         = bit_i ^ w_lfsr_base[LFSR_TAP_HI];
    assign w_push      = w_take & (w_bit_base == LAST_BIT);
    assign w_last_word = (w_word_base == LAST_WORD);
    assign w_word_data = {w_sh_base, w_d};

    always_ff @(posedge clk_i or negedge reset_n_period) begin
        if (!reset_n_period) begin
            r_state      <= ST_IDLE;
            r_sync_d     <= 1'b0;
            r_lfsr       <= LFSR_SEED;
            r_sh         <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= 8'd0;
            r_frame_done <= 1'b0;
            r_locked     <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_sync_d     <= sync_i;
            r_frame_done <= 1'b0;
            if (clr_i) begin
                r_sync_err <= 1'b0;
            end

            if (!dec_en_i) begin
                // Stream went invalid: partial frame content is abandoned.
                if ((r_state == ST_SYNCED) && w_partial) begin
                    r_sync_err <= 1'b1;
                end
                r_state  <= ST_IDLE;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_HUNT;
                    end
                    ST_HUNT, ST_SYNCED: begin
                        if (w_restart) begin
                            if ((r_state == ST_SYNCED) && w_partial) begin
                                r_sync_err <= 1'b1;
                            end
                            r_state  <= ST_SYNCED;
                            r_locked <= 1'b1;
                        end
                        if (w_active) begin
                            r_lfsr <= w_take ? lfsr_next(w_lfsr_base) : w_lfsr_base;
                            if (w_push) begin
                                r_sh      <= '0;
                                r_bit_cnt <= '0;
                                if (w_last_word) begin
                                    r_word_cnt   <= 8'd0;
                                    r_frame_done <= 1'b1;
                                    r_state      <= ST_HUNT;
                                    r_locked     <= 1'b0;
                                end else begin
                                    r_word_cnt <= w_word_base + 8'd1;
                                end
                            end else if (w_take) begin
                                r_sh       <= {w_sh_base[WORD_W-3:0], w_d};
                                r_bit_cnt  <= w_bit_base + 1'b1;
                                r_word_cnt <= w_word_base;
                            end else begin
                                r_sh       <= w_sh_base;
                                r_bit_cnt  <= w_bit_base;
                                r_word_cnt <= w_word_base;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    dmc_word_fifo #(
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk_i          (clk_i),
        .reset_n_period (reset_n_period),
        .i_clr          (clr_i),
        .i_push         (w_push),
        .i_data         (w_word_data),
        .i_rdy          (word_rdy_i),
        .o_data         (word_o),
        .o_vld          (word_vld_o),
        .o_ovf          (ovf_o)
    );

    assign frame_done_o = r_frame_done;
    assign locked_o     = r_locked;
    assign sync_err_o   = r_sync_err;

endmodule
